// File: rtl/alu_seq_pkg.sv
// Shared types for the registered sequential ALU: opcodes, FSM states and flag bit positions.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    localparam int FLAG_Z   = 0;
    localparam int FLAG_C   = 1;
    localparam int FLAG_N   = 2;
    localparam int FLAG_V   = 3;
    localparam int FLAG_ILL = 4;
    localparam int FLAG_W   = 5;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative WIDTH x WIDTH shift-add multiplier, one partial product per clock, WIDTH iterations.
// done and product are combinational so the caller can capture the final sum on the last iteration edge.
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] pp;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        pp       = mplier_q[0] ? mcand_q : '0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = CW'(WIDTH - 1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_q + pp;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    assign done    = busy_q && (cnt_q == '0);
    assign product = acc_q + pp;

    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset too, so an aborted multiply leaves no stale partial sum.
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// Registered ALU with valid/ready on both sides; single-cycle ops, flags and the IDLE/BUSY/DONE FSM.
// Define ALU_SEQ_MUL_EN to build opcode 111 as the iterative multiply; otherwise it reports ILL.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALU_SEL,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic [4:0]       FLAGS,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int SW = $clog2(WIDTH);

    alu_state_e          state_q, state_d;
    logic [WIDTH-1:0]    alu_out_q, alu_out_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;

    logic                accept;
    alu_op_e             op;
    logic [SW-1:0]       sh;
    logic [WIDTH:0]      wide;
    logic [WIDTH-1:0]    res;
    logic                c_flag, v_flag, ill_flag;

    function automatic logic [FLAG_W-1:0] pack_flags(input logic [WIDTH-1:0] r,
                                                      input logic c, input logic v,
                                                      input logic ill);
        logic [FLAG_W-1:0] f;
        f           = '0;
        f[FLAG_Z]   = (r == '0);
        f[FLAG_N]   = r[WIDTH-1];
        f[FLAG_C]   = c;
        f[FLAG_V]   = v;
        f[FLAG_ILL] = ill;
        return f;
    endfunction

    assign IN_READY  = !rst && (state_q == ST_IDLE || (state_q == ST_DONE && OUT_READY));
    assign accept    = IN_VALID && IN_READY;
    assign op        = alu_op_e'(ALU_SEL);
    assign sh        = B[SW-1:0];
    assign OUT_VALID = (state_q == ST_DONE);
    assign ALU_OUT   = alu_out_q;
    assign FLAGS     = flags_q;

    // Single-cycle datapath; shifts carry the last bit out through the extra bit of wide.
    always_comb begin
        wide     = '0;
        res      = '0;
        c_flag   = 1'b0;
        v_flag   = 1'b0;
        ill_flag = 1'b0;
        case (op)
            OP_ADD: begin
                wide   = {1'b0, A} + {1'b0, B};
                res    = wide[WIDTH-1:0];
                c_flag = wide[WIDTH];
                v_flag = (A[WIDTH-1] == B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                wide   = {1'b0, A} - {1'b0, B};
                res    = wide[WIDTH-1:0];
                c_flag = wide[WIDTH];
                v_flag = (A[WIDTH-1] != B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: res = A & B;
            OP_OR:  res = A | B;
            OP_XOR: res = A ^ B;
            OP_SHL: begin
                wide   = {1'b0, A} << sh;
                res    = wide[WIDTH-1:0];
                c_flag = wide[WIDTH];
            end
            OP_SHR: begin
                wide   = {A, 1'b0} >> sh;
                res    = wide[WIDTH:1];
                c_flag = wide[0];
            end
            OP_MUL: begin
`ifndef ALU_SEQ_MUL_EN
                ill_flag = 1'b1;
`endif
            end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    always_comb begin
        state_d   = state_q;
        alu_out_d = alu_out_q;
        flags_d   = flags_q;
`ifdef ALU_SEQ_MUL_EN
        mul_start = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d   = ST_DONE;
                    alu_out_d = res;
                    flags_d   = pack_flags(res, c_flag, v_flag, ill_flag);
`ifdef ALU_SEQ_MUL_EN
                    if (op == OP_MUL) begin
                        state_d   = ST_BUSY;
                        alu_out_d = alu_out_q;
                        flags_d   = flags_q;
                        mul_start = 1'b1;
                    end
`endif
                end else if (state_q == ST_DONE && OUT_READY) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            ST_BUSY: begin
                if (mul_done) begin
                    state_d   = ST_DONE;
                    alu_out_d = mul_product[WIDTH-1:0];
                    flags_d   = pack_flags(mul_product[WIDTH-1:0],
                                           |mul_product[2*WIDTH-1:WIDTH], 1'b0, 1'b0);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            alu_out_q <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
            flags_q   <= flags_d;
        end
    end

endmodule
